// File: rtl/secuenciador_instr.sv
// Instruction sequencer: loadable program memory + PC, issues a run of words to the datapath.
// Latency: inicio -> first word valid 2 cycles later; one word per 2 cycles with ready held high.
// Backpressure: instr_out/instr_valid hold stable until instr_ready; all outputs are registered.
module secuenciador_instr #(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = 5,
    parameter int INSTR_W    = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carga_we,
    input  logic [ADDR_W-1:0]  carga_dir,
    input  logic [INSTR_W-1:0] carga_dato,
    input  logic               inicio,
    input  logic               paso,
    input  logic [ADDR_W:0]    num_instr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               ocupado,
    output logic               fin
);

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        LEER     = 3'd1,
        EMITIR   = 3'd2,
        PAUSA    = 3'd3,
        TERMINAR = 3'd4
    } estado_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(PROG_DEPTH);

    estado_t             estado_q, estado_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W:0]     cuenta_q, cuenta_d;
    logic [ADDR_W:0]     total_q, total_d;
    logic                paso_q, paso_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                fin_q, fin_d;
    logic                ocupado_q, ocupado_d;

    // Program memory has no reset so a program survives an aborted run.
    logic [INSTR_W-1:0]  mem_q [PROG_DEPTH];

    // Program load: only while idle, so a running program can never be modified.
    always_ff @(posedge clk) begin
        if (carga_we && (estado_q == REPOSO)) begin
            mem_q[carga_dir] <= carga_dato;
        end
    end

    // Next state, PC/count bookkeeping and the output word register.
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        cuenta_d = cuenta_q;
        total_d  = total_q;
        paso_d   = paso_q;
        instr_d  = '0;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    if (num_instr == '0) begin
                        estado_d = TERMINAR;
                    end else begin
                        estado_d = LEER;
                        pc_d     = '0;
                        cuenta_d = '0;
                        paso_d   = paso;
                        total_d  = (num_instr > DEPTH_C) ? DEPTH_C : num_instr;
                    end
                end
            end
            LEER: begin
                // Registered read straight into the output register.
                instr_d  = mem_q[pc_q];
                estado_d = EMITIR;
            end
            EMITIR: begin
                instr_d = instr_q;
                if (instr_ready) begin
                    // Word consumed: clear the bus so it reads zero while not valid.
                    instr_d  = '0;
                    pc_d     = pc_q + 1'b1;
                    cuenta_d = cuenta_q + 1'b1;
                    if (cuenta_d == total_q) begin
                        estado_d = TERMINAR;
                    end else if (paso_q) begin
                        estado_d = PAUSA;
                    end else begin
                        estado_d = LEER;
                    end
                end
            end
            PAUSA: begin
                if (inicio) begin
                    estado_d = LEER;
                end
            end
            TERMINAR: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        // Status outputs are decoded from the next state and registered.
        valid_d   = (estado_d == EMITIR);
        fin_d     = (estado_d == TERMINAR);
        ocupado_d = (estado_d != REPOSO);
    end

    // State and output registers; reset aborts a run on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            pc_q      <= '0;
            cuenta_q  <= '0;
            total_q   <= '0;
            paso_q    <= 1'b0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            fin_q     <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pc_q      <= pc_d;
            cuenta_q  <= cuenta_d;
            total_q   <= total_d;
            paso_q    <= paso_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fin_q     <= fin_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign ocupado     = ocupado_q;
    assign fin         = fin_q;

endmodule

// File: tb/tb_secuenciador_instr.sv
// Scoreboard bench for secuenciador_instr: expected words queued at run start, popped on handshakes.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// All waits are bounded by cycle budgets.
module tb_secuenciador_instr;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        carga_we;
    logic [4:0]  carga_dir;
    logic [19:0] carga_dato;
    logic        inicio;
    logic        paso;
    logic [5:0]  num_instr;
    logic [19:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  pc;
    logic        ocupado;
    logic        fin;

    secuenciador_instr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .carga_we    (carga_we),
        .carga_dir   (carga_dir),
        .carga_dato  (carga_dato),
        .inicio      (inicio),
        .paso        (paso),
        .num_instr   (num_instr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .ocupado     (ocupado),
        .fin         (fin)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] sb_q [$];
    logic [19:0] model_mem [DEPTH];
    int          hs_stamp [$];
    int          cyc = 0;
    int          hs_cnt = 0;
    int          fin_cnt = 0;
    int          valid_cnt = 0;
    int          last_fin = 0;
    int          t_start = 0;
    int          t_idle = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pop on every handshake, idle bus must read zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_valid) valid_cnt++;
            if (instr_valid && instr_ready) begin
                hs_cnt++;
                hs_stamp.push_back(cyc);
                if (sb_q.size() == 0) check("sb_extra", 1, 0);
                else check("sb_dat", instr_out, sb_q.pop_front());
            end
            if (!instr_valid) check("idle_zero", instr_out, 0);
            if (fin) begin
                fin_cnt++;
                last_fin = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [19:0] d, input bit upd);
        carga_we   = 1'b1;
        carga_dir  = 5'(a);
        carga_dato = d;
        step();
        carga_we   = 1'b0;
        if (upd) model_mem[a] = d;
    endtask

    task automatic start_run(input int n, input bit p);
        int eff;
        eff = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < eff; i++) sb_q.push_back(model_mem[i % DEPTH]);
        inicio    = 1'b1;
        num_instr = 6'(n);
        paso      = p;
        step();
        inicio    = 1'b0;
        t_start   = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (ocupado && k < budget) begin
            @(negedge clk);
            k++;
        end
        t_idle = cyc;
        check("idle_timeout", ocupado, 0);
        step();
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!instr_valid && k < budget);
        check("valid_timeout", instr_valid, 1);
    endtask

    initial begin
        int hs0, fin0, val0;
        int k;

        rst_n = 1'b0; carga_we = 1'b0; carga_dir = '0; carga_dato = '0;
        inicio = 1'b0; paso = 1'b0; num_instr = '0; instr_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", instr_valid, 0);
        check("rst_out", instr_out, 0);
        check("rst_pc", pc, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_fin", fin, 0);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;

        // Basic continuous run, 2-cycle cadence.
        load(0, 20'hC0805, 1'b1);
        load(1, 20'hC1023, 1'b1);
        load(2, 20'h00000, 1'b1);
        hs_stamp.delete();
        hs0 = hs_cnt; fin0 = fin_cnt; val0 = valid_cnt;
        start_run(3, 1'b0);
        wait_idle(30);
        check("t1_hs", hs_stamp.size(), 3);
        if (hs_stamp.size() == 3) begin
            check("t1_first_lat", hs_stamp[0], t_start + 1);
            check("t1_gap1", hs_stamp[1], hs_stamp[0] + 2);
            check("t1_gap2", hs_stamp[2], hs_stamp[1] + 2);
            check("t1_fin_lat", last_fin, hs_stamp[2] + 1);
        end
        check("t1_idle_lat", t_idle, last_fin + 1);
        check("t1_fin", fin_cnt - fin0, 1);
        check("t1_valid_cycles", valid_cnt - val0, 3);
        check("t1_pc", pc, 3);

        // Backpressure on the first word.
        instr_ready = 1'b0;
        hs0 = hs_cnt; fin0 = fin_cnt; val0 = valid_cnt;
        start_run(3, 1'b0);
        wait_valid(10);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("t2_hold_valid", instr_valid, 1);
            check("t2_hold_out", instr_out, 20'hC0805);
            check("t2_hold_pc", pc, 0);
            step();
        end
        instr_ready = 1'b1;
        wait_idle(30);
        check("t2_valid_cycles", valid_cnt - val0, 7);
        check("t2_hs", hs_cnt - hs0, 3);
        check("t2_fin", fin_cnt - fin0, 1);

        // Single-step mode.
        hs_stamp.delete();
        hs0 = hs_cnt; fin0 = fin_cnt;
        start_run(2, 1'b1);
        k = 0;
        while (hs_cnt == hs0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t3_first_hs", hs_cnt - hs0, 1);
        repeat (5) begin
            @(negedge clk);
            check("t3_pause_valid", instr_valid, 0);
            check("t3_pause_busy", ocupado, 1);
        end
        step();
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        t_start = cyc;
        wait_idle(30);
        check("t3_hs", hs_stamp.size(), 2);
        if (hs_stamp.size() == 2) check("t3_step_lat", hs_stamp[1], t_start + 1);
        check("t3_fin", fin_cnt - fin0, 1);

        // Saturating count and wrap.
        for (int i = 0; i < DEPTH; i++) load(i, 20'(i * 32'h1357 + 3), 1'b1);
        hs0 = hs_cnt; fin0 = fin_cnt;
        start_run(40, 1'b0);
        wait_idle(200);
        check("t4_hs", hs_cnt - hs0, 32);
        check("t4_pc_wrap", pc, 0);
        check("t4_fin", fin_cnt - fin0, 1);

        // Zero-length run: fin only.
        hs0 = hs_cnt; fin0 = fin_cnt; val0 = valid_cnt;
        start_run(0, 1'b0);
        wait_idle(10);
        check("t4z_valid", valid_cnt - val0, 0);
        check("t4z_fin", fin_cnt - fin0, 1);

        // Load and inicio during a run are ignored.
        instr_ready = 1'b0;
        hs0 = hs_cnt; fin0 = fin_cnt;
        start_run(3, 1'b0);
        wait_valid(10);
        load(1, 20'hFFFFF, 1'b0);
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        instr_ready = 1'b1;
        wait_idle(30);
        check("t5_hs", hs_cnt - hs0, 3);
        check("t5_fin", fin_cnt - fin0, 1);
        start_run(3, 1'b0);
        wait_idle(30);
        check("t5_pc", pc, 3);

        // Reset mid-run.
        instr_ready = 1'b0;
        start_run(3, 1'b0);
        wait_valid(10);
        fin0 = fin_cnt;
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check("t6_valid", instr_valid, 0);
        check("t6_out", instr_out, 0);
        check("t6_busy", ocupado, 0);
        check("t6_fin", fin, 0);
        check("t6_pc", pc, 0);
        sb_q.delete();
        rst_n = 1'b1;
        step();
        step();
        check("t6_no_fin", fin_cnt - fin0, 0);
        instr_ready = 1'b1;
        hs0 = hs_cnt; fin0 = fin_cnt;
        start_run(3, 1'b0);
        wait_idle(30);
        check("t6_rerun_hs", hs_cnt - hs0, 3);
        check("t6_rerun_fin", fin_cnt - fin0, 1);

        check("sb_leftover", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
